regfile_wb_arbiter: RTL



---
 rtl/regfile_wb_arbiter.sv | 104 ++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter that shares the regfile write port between ALU and LSU writeback.
// Optional decode bypass ports are enabled by defining REGFILE_WB_FWD_EN.
module regfile_wb_arbiter #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 5
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            hold,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [AW-1:0]   lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
`ifdef REGFILE_WB_FWD_EN
  input  logic [AW-1:0]   read_address1,
  input  logic [AW-1:0]   read_address2,
  output logic            fwd_hit1,
  output logic            fwd_hit2,
  output logic [XLEN-1:0] fwd_data1,
  output logic [XLEN-1:0] fwd_data2,
`endif
  output logic            rf_write_enable,
  output logic [AW-1:0]   rf_write_address,
  output logic [XLEN-1:0] rf_write_data,
  output logic            last_grant
);

  typedef enum logic {GrantAlu = 1'b0, GrantLsu = 1'b1} grant_e;

  grant_e            last_grant_q, last_grant_d;
  logic              we_q, we_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [XLEN-1:0]   data_q, data_d;
  logic              alu_accept, lsu_accept;

  // Ties go to the source that did not win last time.
  always_comb begin
    alu_ready = 1'b0;
    lsu_ready = 1'b0;
    if (reset_n && !hold) begin
      if (alu_valid && lsu_valid) begin
        alu_ready = (last_grant_q == GrantLsu);
        lsu_ready = (last_grant_q == GrantAlu);
      end else begin
        alu_ready = alu_valid;
        lsu_ready = lsu_valid;
      end
    end
  end

  assign alu_accept = alu_valid && alu_ready;
  assign lsu_accept = lsu_valid && lsu_ready;

  // The output stage drains every cycle; x0 writes still load address/data but never strobe.
  always_comb begin
    last_grant_d = last_grant_q;
    we_d         = 1'b0;
    addr_d       = addr_q;
    data_d       = data_q;
    if (alu_accept) begin
      last_grant_d = GrantAlu;
      we_d         = (alu_rd != '0);
      addr_d       = alu_rd;
      data_d       = alu_data;
    end else if (lsu_accept) begin
      last_grant_d = GrantLsu;
      we_d         = (lsu_rd != '0);
      addr_d       = lsu_rd;
      data_d       = lsu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_grant_q <= GrantLsu;
      we_q         <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
    end
  end

  assign rf_write_enable  = we_q;
  assign rf_write_address = addr_q;
  assign rf_write_data    = data_q;
  assign last_grant       = last_grant_q;

`ifdef REGFILE_WB_FWD_EN
  // Bypass the write that commits at the end of this cycle.
  assign fwd_hit1  = we_q && (read_address1 == addr_q);
  assign fwd_hit2  = we_q && (read_address2 == addr_q);
  assign fwd_data1 = fwd_hit1 ? data_q : '0;
  assign fwd_data2 = fwd_hit2 ? data_q : '0;
`endif

endmodule
